// File: rtl/ste_pkg.sv
// Shared types, legal parameter ranges and width helpers for the ste_* filter family.
package ste_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  localparam int unsigned LOG2_LEN_MIN = 1;
  localparam int unsigned LOG2_LEN_MAX = 8;
  localparam int unsigned DATA_W_MIN   = 2;
  localparam int unsigned DATA_W_MAX   = 32;

  // Running sum of N samples of data_w bits needs clog2(N) extra bits.
  function automatic int acc_width(input int data_w, input int log2_len);
    return data_w + $clog2(2 ** log2_len);
  endfunction

endpackage

// File: rtl/ste_mavg_if.sv
// Streaming sample interface of ste_mavg: input samples with strobe and clear, averaged output with status.
interface ste_mavg_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] din_i;
  logic              din_vld_i;
  logic              clr_i;
  logic [DATA_W-1:0] dout_o;
  logic              dout_vld_o;
  logic              filled_o;

  modport master (
    output din_i, din_vld_i, clr_i,
    input  dout_o, dout_vld_o, filled_o
  );

  modport slave (
    input  din_i, din_vld_i, clr_i,
    output dout_o, dout_vld_o, filled_o
  );

endinterface

// File: rtl/ste_mavg_dly.sv
// N-entry circular delay line: presents the oldest sample and overwrites it on each write.
module ste_mavg_dly
  import ste_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_LEN = 2
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] oldest_o
);

  localparam int N = 2 ** LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0]   dly_q [N];
  logic [LOG2_LEN-1:0] wr_ptr_q;

  // The slot about to be overwritten holds the sample leaving the window.
  assign oldest_o = dly_q[wr_ptr_q];

  // NOTE: this array is reset and cleared on purpose; the warm-up ramp relies
  // on every slot reading zero until a real sample has been written there.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < N; i++) dly_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < N; i++) dly_q[i] <= '0;
    end else if (wr_en_i) begin
      dly_q[wr_ptr_q] <= din_i;
      wr_ptr_q        <= wr_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/ste_mavg.sv
// Moving average over 2^LOG2_LEN samples using a running-sum accumulator and a circular delay line.
module ste_mavg
  import ste_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_LEN = 2,
  parameter int ROUND    = 0
) (
  input logic          clk,
  input logic          reset_ni,
  ste_mavg_if.slave    bus
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_LEN);
  localparam round_mode_e RMODE = (ROUND != 0) ? RND_HALF_UP : RND_TRUNC;
  localparam logic [ACC_W-1:0] RND_ADD =
    (RMODE == RND_HALF_UP) ? (ACC_W'(1) << (LOG2_LEN - 1)) : '0;
  localparam logic [LOG2_LEN:0] FILL_N   = {1'b1, {LOG2_LEN{1'b0}}};
  localparam logic [LOG2_LEN:0] FILL_ONE = 1;

  if (LOG2_LEN < LOG2_LEN_MIN || LOG2_LEN > LOG2_LEN_MAX) begin : g_bad_len
    $error("ste_mavg: LOG2_LEN out of legal range");
  end
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
    $error("ste_mavg: DATA_W out of legal range");
  end
  if (ROUND != 0 && ROUND != 1) begin : g_bad_round
    $error("ste_mavg: ROUND must be 0 or 1");
  end

  logic              accept;
  logic [DATA_W-1:0] oldest;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  sum_rnd;
  logic [LOG2_LEN:0] fill_cnt_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q;

  // A sample arriving together with a clear is dropped.
  assign accept = bus.din_vld_i && !bus.clr_i;

  ste_mavg_dly #(
    .DATA_W   (DATA_W),
    .LOG2_LEN (LOG2_LEN)
  ) u_dly (
    .clk      (clk),
    .reset_ni (reset_ni),
    .clr_i    (bus.clr_i),
    .wr_en_i  (accept),
    .din_i    (bus.din_i),
    .oldest_o (oldest)
  );

  // NOTE: combinational blocks assign every output a default first so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    acc_nxt = acc_q;
    sum_rnd = '0;
    // The true sum is never negative, so modular add/subtract stays exact.
    acc_nxt = acc_q + ACC_W'(bus.din_i) - ACC_W'(oldest);
    sum_rnd = acc_nxt + RND_ADD;
  end

  // NOTE: clocked state is updated with non-blocking assignments only, so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q      <= '0;
      fill_cnt_q <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (bus.clr_i) begin
      acc_q      <= '0;
      fill_cnt_q <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= accept;
      if (accept) begin
        acc_q  <= acc_nxt;
        dout_q <= sum_rnd[ACC_W-1:LOG2_LEN];
        if (fill_cnt_q != FILL_N) fill_cnt_q <= fill_cnt_q + FILL_ONE;
      end
    end
  end

  assign bus.dout_o     = dout_q;
  assign bus.dout_vld_o = dout_vld_q;
  assign bus.filled_o   = (fill_cnt_q == FILL_N);

endmodule

// File: tb/tb_ste_mavg.sv
// Directed bench for ste_mavg: a truncating and a rounding instance driven with identical stimulus.
module tb_ste_mavg;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ste_mavg_if #(.DATA_W(16)) t_if ();
  ste_mavg_if #(.DATA_W(16)) r_if ();

  ste_mavg #(.DATA_W(16), .LOG2_LEN(2), .ROUND(0)) u_trunc (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (t_if)
  );

  ste_mavg #(.DATA_W(16), .LOG2_LEN(2), .ROUND(1)) u_round (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (r_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one input cycle to both instances, then sample just after the edge.
  task automatic step(input logic vld, input logic [15:0] d, input logic c);
    t_if.din_i = d;  t_if.din_vld_i = vld;  t_if.clr_i = c;
    r_if.din_i = d;  r_if.din_vld_i = vld;  r_if.clr_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e_t, input logic [15:0] e_r,
                            input logic e_vld, input logic e_fill);
    check({tag, ".dout_t"},  32'(t_if.dout_o),     32'(e_t));
    check({tag, ".dout_r"},  32'(r_if.dout_o),     32'(e_r));
    check({tag, ".vld"},     32'(t_if.dout_vld_o), 32'(e_vld));
    check({tag, ".vld_r"},   32'(r_if.dout_vld_o), 32'(e_vld));
    check({tag, ".filled"},  32'(t_if.filled_o),   32'(e_fill));
    check({tag, ".filled_r"},32'(r_if.filled_o),   32'(e_fill));
  endtask

  initial begin
    t_if.din_i = '0; t_if.din_vld_i = 1'b0; t_if.clr_i = 1'b0;
    r_if.din_i = '0; r_if.din_vld_i = 1'b0; r_if.clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("in_reset", 16'd0, 16'd0, 1'b0, 1'b0);
    reset_ni = 1'b1;
    step(1'b0, 16'd0, 1'b0);
    expect_out("post_reset", 16'd0, 16'd0, 1'b0, 1'b0);

    // Step response and wrap: fifth sample evicts the first.
    step(1'b1, 16'd100, 1'b0); expect_out("step1", 16'd25,  16'd25,  1'b1, 1'b0);
    step(1'b1, 16'd100, 1'b0); expect_out("step2", 16'd50,  16'd50,  1'b1, 1'b0);
    step(1'b1, 16'd100, 1'b0); expect_out("step3", 16'd75,  16'd75,  1'b1, 1'b0);
    step(1'b1, 16'd100, 1'b0); expect_out("step4", 16'd100, 16'd100, 1'b1, 1'b1);
    step(1'b1, 16'd100, 1'b0); expect_out("step5", 16'd100, 16'd100, 1'b1, 1'b1);
    step(1'b1, 16'd20,  1'b0); expect_out("wrap",  16'd80,  16'd80,  1'b1, 1'b1);
    step(1'b0, 16'd0,   1'b1); expect_out("clr_a", 16'd0,   16'd0,   1'b0, 1'b0);

    // Rounding: 2 then zeros, then a lone 1.
    step(1'b1, 16'd2, 1'b0); expect_out("rnd2",  16'd0, 16'd1, 1'b1, 1'b0);
    step(1'b1, 16'd0, 1'b0); expect_out("rnd2z1", 16'd0, 16'd1, 1'b1, 1'b0);
    step(1'b1, 16'd0, 1'b0);
    step(1'b1, 16'd0, 1'b0); expect_out("rnd2z3", 16'd0, 16'd1, 1'b1, 1'b1);
    step(1'b1, 16'd0, 1'b0); expect_out("rnd2z4", 16'd0, 16'd0, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    step(1'b1, 16'd1, 1'b0); expect_out("rnd1",  16'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1); expect_out("clr_b", 16'd0, 16'd0, 1'b0, 1'b0);

    // Full scale up and down.
    step(1'b1, 16'hFFFF, 1'b0); expect_out("fs1", 16'h3FFF, 16'h4000, 1'b1, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0); expect_out("fs2", 16'h7FFF, 16'h8000, 1'b1, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0); expect_out("fs3", 16'hBFFF, 16'hBFFF, 1'b1, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0); expect_out("fs4", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0); expect_out("fs5", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 1'b0); expect_out("fz1", 16'hBFFF, 16'hBFFF, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 1'b0); expect_out("fz2", 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 1'b0); expect_out("fz3", 16'h3FFF, 16'h4000, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 1'b0); expect_out("fz4", 16'h0000, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b1);

    // Gapped valid: a sample every third cycle, output holds in between.
    step(1'b1, 16'd8,  1'b0); expect_out("gap8",   16'd2,  16'd2,  1'b1, 1'b0);
    step(1'b0, 16'd0,  1'b0); expect_out("gap8h",  16'd2,  16'd2,  1'b0, 1'b0);
    step(1'b0, 16'd0,  1'b0);
    step(1'b1, 16'd16, 1'b0); expect_out("gap16",  16'd6,  16'd6,  1'b1, 1'b0);
    step(1'b0, 16'd0,  1'b0); expect_out("gap16h", 16'd6,  16'd6,  1'b0, 1'b0);
    step(1'b0, 16'd0,  1'b0);
    step(1'b1, 16'd24, 1'b0); expect_out("gap24",  16'd12, 16'd12, 1'b1, 1'b0);
    step(1'b0, 16'd0,  1'b0);
    step(1'b0, 16'd0,  1'b0); expect_out("gap24h", 16'd12, 16'd12, 1'b0, 1'b0);
    step(1'b1, 16'd32, 1'b0); expect_out("gap32",  16'd20, 16'd20, 1'b1, 1'b1);
    step(1'b0, 16'd0,  1'b0); expect_out("gap32h", 16'd20, 16'd20, 1'b0, 1'b1);
    step(1'b0, 16'd0,  1'b1);

    // Clear mid-stream drops the coincident sample.
    step(1'b1, 16'd100, 1'b0);
    step(1'b1, 16'd100, 1'b0);
    step(1'b1, 16'd100, 1'b0); expect_out("cm3",   16'd75, 16'd75, 1'b1, 1'b0);
    step(1'b1, 16'd500, 1'b1); expect_out("cmclr", 16'd0,  16'd0,  1'b0, 1'b0);
    step(1'b1, 16'd40,  1'b0); expect_out("cm40",  16'd10, 16'd10, 1'b1, 1'b0);
    step(1'b0, 16'd0,   1'b1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 6; i++) step(1'b1, 16'd100, 1'b0);
    expect_out("ar6", 16'd100, 16'd100, 1'b1, 1'b1);
    reset_ni = 1'b0;
    #2;
    expect_out("ar_async", 16'd0, 16'd0, 1'b0, 1'b0);
    #1;
    reset_ni = 1'b1;
    step(1'b1, 16'd100, 1'b0); expect_out("ar_first", 16'd25, 16'd25, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
